// File: rtl/barrier_pkg.sv
// Shared types and helpers for the barrier actuator: state encoding,
// motor drive patterns and small state-classification functions.
package barrier_pkg;

  typedef enum logic [2:0] {
    IS_UP    = 3'd0,
    WARN     = 3'd1,
    LOWERING = 3'd2,
    IS_DOWN  = 3'd3,
    RAISING  = 3'd4,
    FAULT    = 3'd5
  } state_t;

  // Motor drive patterns, packed as {motor_up, motor_down}.
  // No pattern ever sets both bits.
  localparam logic [1:0] MOTOR_OFF  = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b10;
  localparam logic [1:0] MOTOR_DOWN = 2'b01;

  // States in which the warning lamp follows the flasher phase.
  function automatic logic is_flashing(input state_t s);
    return (s == WARN) || (s == LOWERING) || (s == IS_DOWN) || (s == RAISING);
  endfunction

  // FAULT and every unused code behave as the latched fault state.
  function automatic logic is_fault(input state_t s);
    return !((s == IS_UP) || (s == WARN) || (s == LOWERING) ||
             (s == IS_DOWN) || (s == RAISING));
  endfunction

  // Motor drive for a given state; only the two motion states drive.
  function automatic logic [1:0] motor_for(input state_t s);
    logic [1:0] m;
    m = MOTOR_OFF;
    if (s == RAISING)  m = MOTOR_UP;
    if (s == LOWERING) m = MOTOR_DOWN;
    return m;
  endfunction

endpackage

// File: rtl/barrier_flasher.sv
// Warning-lamp phase generator. The phase toggles every FLASH_HALF enabled
// cycles; restart forces the phase high with a fresh half-period. The port
// presents the phase value that will be held after the coming edge, so the
// parent can register its lamp output on that same edge.
module barrier_flasher
  import barrier_pkg::*;
#(
  parameter int FLASH_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic phase_next
);

  localparam int CW = $clog2(FLASH_HALF) + 1;
  localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          phase;

  // Work out the half-period count and phase that follow this cycle.
  always_comb begin
    count_next = count;
    phase_next = phase;
    if (restart) begin
      count_next = '0;
      phase_next = 1'b1;
    end else if (enable) begin
      if (count == LAST) begin
        count_next = '0;
        phase_next = ~phase;
      end else begin
        count_next = count + CW'(1);
      end
    end
  end

  // Hold the half-period count and current phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      phase <= 1'b0;
    end else begin
      count <= count_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/barrier_actuator.sv
// Barrier actuator: turns the crossing controller's up/down command into
// motor drive with a flashing pre-lowering warning, supervises motion with
// the limit switches and a timeout, and latches a fault until the operator
// clears it. Outputs are registered from the next state so they change on
// the same edge as the state itself.
module barrier_actuator
  import barrier_pkg::*;
#(
  parameter int WARN_CYCLES  = 8,
  parameter int MOVE_TIMEOUT = 16,
  parameter int FLASH_HALF   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       barrier_ctrl,
  input  logic       lim_up,
  input  logic       lim_down,
  input  logic       fault_clr,
  output logic       motor_up,
  output logic       motor_down,
  output logic       lamp,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int WW = $clog2(WARN_CYCLES) + 1;
  localparam int TW = $clog2(MOVE_TIMEOUT) + 1;
  localparam logic [WW-1:0] WARN_LOAD = WW'(WARN_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(MOVE_TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic [WW-1:0] warn_cnt;
  logic [WW-1:0] warn_next;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_next;
  logic [1:0]    motor_next;
  logic          flash_en;
  logic          flash_restart;
  logic          phase_next;

  // Decide the next state and counter values; both limits at once always
  // wins, then within a state a limit beats a command and a command beats
  // the timeout.
  always_comb begin
    state_next = state;
    warn_next  = warn_cnt;
    tmo_next   = tmo_cnt;
    if (lim_up && lim_down) begin
      state_next = FAULT;
    end else begin
      case (state)
        IS_UP: begin
          if (!barrier_ctrl) begin
            state_next = WARN;
            warn_next  = WARN_LOAD;
          end
        end
        WARN: begin
          if (barrier_ctrl) begin
            state_next = IS_UP;
          end else if (warn_cnt == '0) begin
            state_next = LOWERING;
            tmo_next   = TMO_LOAD;
          end else begin
            warn_next = warn_cnt - WW'(1);
          end
        end
        LOWERING: begin
          if (lim_down) begin
            state_next = IS_DOWN;
          end else if (barrier_ctrl) begin
            state_next = RAISING;
            tmo_next   = TMO_LOAD;
          end else if (tmo_cnt == '0) begin
            state_next = FAULT;
          end else begin
            tmo_next = tmo_cnt - TW'(1);
          end
        end
        IS_DOWN: begin
          if (barrier_ctrl) begin
            state_next = RAISING;
            tmo_next   = TMO_LOAD;
          end else if (!lim_down) begin
            state_next = LOWERING;
            tmo_next   = TMO_LOAD;
          end
        end
        RAISING: begin
          if (lim_up) begin
            state_next = IS_UP;
          end else if (!barrier_ctrl) begin
            state_next = LOWERING;
            tmo_next   = TMO_LOAD;
          end else if (tmo_cnt == '0) begin
            state_next = FAULT;
          end else begin
            tmo_next = tmo_cnt - TW'(1);
          end
        end
        default: begin
          if (fault_clr) begin
            state_next = barrier_ctrl ? RAISING : LOWERING;
            tmo_next   = TMO_LOAD;
          end
        end
      endcase
    end
  end

  assign motor_next    = motor_for(state_next);
  assign flash_en      = is_flashing(state);
  assign flash_restart = (state == IS_UP) && (state_next == WARN);
  assign state_o       = state;

  barrier_flasher #(
    .FLASH_HALF (FLASH_HALF)
  ) u_flasher (
    .clk        (clk),
    .rst        (rst),
    .enable     (flash_en),
    .restart    (flash_restart),
    .phase_next (phase_next)
  );

  // Register state, counters and the outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IS_UP;
      warn_cnt   <= '0;
      tmo_cnt    <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      lamp       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      warn_cnt   <= warn_next;
      tmo_cnt    <= tmo_next;
      motor_up   <= motor_next[1];
      motor_down <= motor_next[0];
      lamp       <= is_flashing(state_next) ? phase_next : is_fault(state_next);
      fault      <= is_fault(state_next);
    end
  end

endmodule

// File: tb/tb_barrier_actuator.sv
// Bench for barrier_actuator: a simple barrier position plant feeds the limit
// switches, directed scenarios plus random command/clear/jam traffic drive
// the inputs, and a behavioural model predicts every output each cycle.
module tb_barrier_actuator;

  localparam int WC      = 8;
  localparam int MT      = 16;
  localparam int FH      = 2;
  localparam int POS_MAX = 6;

  localparam int S_UP    = 0;
  localparam int S_WARN  = 1;
  localparam int S_LOWER = 2;
  localparam int S_DOWN  = 3;
  localparam int S_RAISE = 4;
  localparam int S_FAULT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       barrier_ctrl = 1'b1;
  logic       lim_up = 1'b1;
  logic       lim_down = 1'b0;
  logic       fault_clr = 1'b0;
  logic       motor_up;
  logic       motor_down;
  logic       lamp;
  logic       fault;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  // Reference model: state plus elapsed-time counts since entry.
  int m_st;
  int warned;
  int moved;
  int ticks;
  bit base;

  // Plant and stimulus knobs.
  int pos;
  bit cmd;
  bit clr;
  bit jam;
  bit contra;

  int first_md;
  int edges;
  bit md_seen;

  always #5 clk = ~clk;

  barrier_actuator #(
    .WARN_CYCLES  (WC),
    .MOVE_TIMEOUT (MT),
    .FLASH_HALF   (FH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .barrier_ctrl (barrier_ctrl),
    .lim_up       (lim_up),
    .lim_down     (lim_down),
    .fault_clr    (fault_clr),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .lamp         (lamp),
    .fault        (fault),
    .state_o      (state_o)
  );

  function automatic bit flashing(input int s);
    return (s == S_WARN) || (s == S_LOWER) || (s == S_DOWN) || (s == S_RAISE);
  endfunction

  task automatic modelReset();
    m_st   = S_UP;
    warned = 0;
    moved  = 0;
    ticks  = 0;
    base   = 1'b0;
  endtask

  task automatic modelStep(input bit c, input bit lu, input bit ld, input bit fc);
    int prev;
    prev = m_st;
    if (lu && ld) begin
      m_st = S_FAULT;
    end else begin
      case (prev)
        S_UP:    if (!c) begin m_st = S_WARN; warned = 1; end
        S_WARN:  if (c) m_st = S_UP;
                 else if (warned >= WC) begin m_st = S_LOWER; moved = 1; end
                 else warned++;
        S_LOWER: if (ld) m_st = S_DOWN;
                 else if (c) begin m_st = S_RAISE; moved = 1; end
                 else if (moved >= MT) m_st = S_FAULT;
                 else moved++;
        S_DOWN:  if (c) begin m_st = S_RAISE; moved = 1; end
                 else if (!ld) begin m_st = S_LOWER; moved = 1; end
        S_RAISE: if (lu) m_st = S_UP;
                 else if (!c) begin m_st = S_LOWER; moved = 1; end
                 else if (moved >= MT) m_st = S_FAULT;
                 else moved++;
        default: if (fc) begin m_st = c ? S_RAISE : S_LOWER; moved = 1; end
      endcase
    end
    if (prev == S_UP && m_st == S_WARN) begin
      base  = 1'b1;
      ticks = 0;
    end else if (flashing(prev)) begin
      ticks++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic compareAll();
    bit exp_lamp;
    exp_lamp = flashing(m_st) ? (base ^ bit'((ticks / FH) % 2)) : (m_st == S_FAULT);
    checkOutput("state_o", {5'b0, state_o}, 8'(m_st));
    checkOutput("motor_up", {7'b0, motor_up}, 8'(m_st == S_RAISE));
    checkOutput("motor_down", {7'b0, motor_down}, 8'(m_st == S_LOWER));
    checkOutput("lamp", {7'b0, lamp}, 8'(exp_lamp));
    checkOutput("fault", {7'b0, fault}, 8'(m_st == S_FAULT));
  endtask

  task automatic applyStimulus(input bit c, input bit lu, input bit ld, input bit fc);
    barrier_ctrl = c;
    lim_up       = lu;
    lim_down     = ld;
    fault_clr    = fc;
    @(posedge clk);
    modelStep(c, lu, ld, fc);
    #1;
    compareAll();
  endtask

  task automatic stepCycle();
    bit lu;
    bit ld;
    lu = (pos >= POS_MAX) || contra;
    ld = (pos <= 0) || contra;
    applyStimulus(cmd, lu, ld, clr);
    if (!jam) begin
      if (motor_up && pos < POS_MAX) pos++;
      else if (motor_down && pos > 0) pos--;
    end
  endtask

  initial begin
    modelReset();
    pos = POS_MAX; cmd = 1'b1; clr = 1'b0; jam = 1'b0; contra = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {5'b0, state_o}, 8'd0);
    checkOutput("reset_motor_up", {7'b0, motor_up}, 8'd0);
    checkOutput("reset_motor_down", {7'b0, motor_down}, 8'd0);
    checkOutput("reset_lamp", {7'b0, lamp}, 8'd0);
    checkOutput("reset_fault", {7'b0, fault}, 8'd0);
    rst = 1'b1;
    repeat (3) stepCycle();

    cmd = 1'b0; edges = 0; first_md = 0;
    repeat (12) begin
      stepCycle();
      edges++;
      if (motor_down && first_md == 0) first_md = edges;
    end
    checkOutput("lower_latency", 8'(first_md), 8'(WC + 1));
    repeat (10) stepCycle();
    checkOutput("lowered_is_down", {5'b0, state_o}, 8'd3);

    cmd = 1'b1;
    repeat (12) stepCycle();
    checkOutput("raised_is_up", {5'b0, state_o}, 8'd0);

    cmd = 1'b0; md_seen = 1'b0;
    repeat (3) begin stepCycle(); md_seen |= motor_down; end
    cmd = 1'b1;
    repeat (3) begin stepCycle(); md_seen |= motor_down; end
    checkOutput("abort_state", {5'b0, state_o}, 8'd0);
    checkOutput("abort_lamp", {7'b0, lamp}, 8'd0);
    checkOutput("abort_no_motor", {7'b0, md_seen}, 8'd0);

    cmd = 1'b0; jam = 1'b1;
    repeat (27) stepCycle();
    checkOutput("timeout_fault", {7'b0, fault}, 8'd1);
    checkOutput("timeout_lamp", {7'b0, lamp}, 8'd1);
    checkOutput("timeout_state", {5'b0, state_o}, 8'd5);
    cmd = 1'b1; clr = 1'b1;
    stepCycle();
    clr = 1'b0; jam = 1'b0;
    checkOutput("clear_raising", {5'b0, state_o}, 8'd4);
    checkOutput("clear_motor_up", {7'b0, motor_up}, 8'd1);
    checkOutput("clear_fault_low", {7'b0, fault}, 8'd0);
    repeat (3) stepCycle();

    cmd = 1'b0;
    repeat (22) stepCycle();
    cmd = 1'b1;
    repeat (3) stepCycle();
    cmd = 1'b0;
    stepCycle();
    checkOutput("reverse_state", {5'b0, state_o}, 8'd2);
    checkOutput("reverse_motor_down", {7'b0, motor_down}, 8'd1);
    checkOutput("reverse_motor_up", {7'b0, motor_up}, 8'd0);
    repeat (8) stepCycle();
    checkOutput("reverse_is_down", {5'b0, state_o}, 8'd3);

    contra = 1'b1;
    stepCycle();
    contra = 1'b0;
    checkOutput("contra_state", {5'b0, state_o}, 8'd5);
    checkOutput("contra_fault", {7'b0, fault}, 8'd1);
    cmd = 1'b1; clr = 1'b1;
    stepCycle();
    clr = 1'b0;
    repeat (12) stepCycle();

    cmd = 1'b0;
    repeat (10) stepCycle();
    checkOutput("pre_reset_lowering", {7'b0, motor_down}, 8'd1);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset_motor", {7'b0, motor_down}, 8'd0);
    checkOutput("async_reset_state", {5'b0, state_o}, 8'd0);
    @(posedge clk);
    #1;
    compareAll();
    rst = 1'b1;
    cmd = 1'b1;
    repeat (15) stepCycle();

    repeat (2000) begin
      if ($urandom_range(15) == 0) cmd = ~cmd;
      clr = ($urandom_range(7) == 0);
      if ($urandom_range(39) == 0) jam = ~jam;
      contra = ($urandom_range(59) == 0);
      stepCycle();
    end
    contra = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
